// File: rtl/halt_ctrl.sv
// halt_ctrl: exit-syscall sequencer (RUN -> KILL -> DRAIN -> MEMWAIT -> HALTED, resume -> RUN).
// Optional cycle/retire statistics counters are compiled in when HALT_CTRL_STATS_EN is defined.
module halt_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int MAX_WAIT     = 255,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             syscall_halt,
  input  logic [31:0]      halt_pc,
  input  logic             mem_busy,
  input  logic             resume,
`ifdef HALT_CTRL_STATS_EN
  input  logic             instr_retire,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
`endif
  output logic             fetch_stall,
  output logic             kill_younger,
  output logic             halted,
  output logic             halt_err,
  output logic [31:0]      halt_pc_q
);

  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES);
  localparam logic [7:0]    WAIT_LAST  = 8'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    KILL    = 3'd1,
    DRAIN   = 3'd2,
    MEMWAIT = 3'd3,
    HALTED  = 3'd4
  } state_t;

  state_t          state_reg, state_next;
  logic [DW-1:0]   drain_reg, drain_next;
  logic [7:0]      wait_reg, wait_next;
  logic            err_next;
  logic [31:0]     pc_next;

  always_comb begin
    state_next = state_reg;
    drain_next = drain_reg;
    wait_next  = wait_reg;
    err_next   = halt_err;
    pc_next    = halt_pc_q;
    case (state_reg)
      RUN: begin
        if (syscall_halt) begin
          state_next = KILL;
          pc_next    = halt_pc;
        end
      end
      KILL: begin
        if (DRAIN_CYCLES == 0) begin
          state_next = MEMWAIT;
          wait_next  = '0;
        end else begin
          state_next = DRAIN;
          drain_next = DRAIN_INIT;
        end
      end
      DRAIN: begin
        if (drain_reg <= DW'(1)) begin
          state_next = MEMWAIT;
          wait_next  = '0;
        end else begin
          drain_next = drain_reg - DW'(1);
        end
      end
      MEMWAIT: begin
        // An idle memory always wins, even on the cycle the timeout would expire.
        if (!mem_busy) begin
          state_next = HALTED;
          err_next   = 1'b0;
        end else if (wait_reg == WAIT_LAST) begin
          state_next = HALTED;
          err_next   = 1'b1;
        end else begin
          wait_next = wait_reg + 8'd1;
        end
      end
      HALTED: begin
        if (resume) begin
          state_next = RUN;
          err_next   = 1'b0;
        end
      end
      default: begin
        state_next = RUN;
        err_next   = 1'b0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet track the state exactly.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg    <= RUN;
      drain_reg    <= '0;
      wait_reg     <= '0;
      fetch_stall  <= 1'b0;
      kill_younger <= 1'b0;
      halted       <= 1'b0;
      halt_err     <= 1'b0;
      halt_pc_q    <= '0;
    end else begin
      state_reg    <= state_next;
      drain_reg    <= drain_next;
      wait_reg     <= wait_next;
      fetch_stall  <= (state_next != RUN);
      kill_younger <= (state_next == KILL);
      halted       <= (state_next == HALTED);
      halt_err     <= err_next;
      halt_pc_q    <= pc_next;
    end
  end

`ifdef HALT_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else if (state_reg == HALTED) begin
      if (resume) begin
        cycle_cnt   <= '0;
        instret_cnt <= '0;
      end
    end else begin
      if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (instr_retire && (instret_cnt != '1)) instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end

`ifndef SYNTHESIS
  logic halted_d;
  always @(posedge clk) begin
    halted_d <= halted;
    if (halted && !halted_d)
      $display("halt_ctrl: halted pc=%h cycles=%0d instret=%0d", halt_pc_q, cycle_cnt, instret_cnt);
  end
`endif
`endif

endmodule

// File: doc/halt_ctrl.md
Name: halt_ctrl

Overview:
Sits directly downstream of the syscall unit and consumes its syscall_halt level.
On an exit syscall it:
- freezes fetch and kills instructions younger than the syscall;
- drains the remaining pipeline stages and waits for outstanding data-memory traffic;
- parks the core in a HALTED state, reporting the exit PC.

The testbench and top level use halted/halt_pc_q to end simulation. resume restarts the core for multi-program runs.

Parameters:
DRAIN_CYCLES, 4, number of cycles to let older in-flight instructions retire after the kill cycle; 0 skips drain.
MAX_WAIT, 255, cycles to wait for mem_busy to deassert before forcing HALTED with error; range 1..255.
CNT_W, 32, width of the statistics counters (optional feature only).

Ports:
clk  input  1  core clock; all state changes on rising edge.
rst_b  input  1  asynchronous active-low reset.
syscall_halt  input  1  exit request from the syscall unit; level, sampled every cycle.
halt_pc  input  32  PC of the exit syscall; valid when syscall_halt=1.
mem_busy  input  1  data memory / write buffer has outstanding transactions.
resume  input  1  restart request; honoured only in HALTED.
fetch_stall  output  1  holds the PC and suppresses fetch.
kill_younger  output  1  one-cycle pulse; invalidate instructions younger than the syscall.
halted  output  1  core is parked.
halt_err  output  1  HALTED was reached via mem_busy timeout.
halt_pc_q  output  32  captured exit PC.

Behaviour:
- Reset (rst_b=0, asynchronous):
  - state=RUN.
  - fetch_stall, kill_younger, halted, halt_err = 0.
  - halt_pc_q = 0; internal counters = 0.
- All outputs are registered (Moore). Latency from syscall_halt=1 in cycle N to fetch_stall=1 and kill_younger=1 is cycle N+1.
- States: RUN, KILL, DRAIN, MEMWAIT, HALTED.
- RUN:
  - Outputs low.
  - syscall_halt=1 -> KILL; halt_pc_q <= halt_pc.
- KILL (exactly 1 cycle):
  - fetch_stall=1, kill_younger=1.
  - Next state: DRAIN with drain counter = DRAIN_CYCLES; if DRAIN_CYCLES=0, MEMWAIT.
- DRAIN:
  - fetch_stall=1.
  - Counter decrements each cycle; leaves when it reaches 1 -> MEMWAIT.
  - Dwell is exactly DRAIN_CYCLES cycles.
- MEMWAIT:
  - fetch_stall=1; wait counter starts at 0 on entry and increments while mem_busy=1.
  - mem_busy=0 -> HALTED, halt_err=0. This includes the first MEMWAIT cycle, giving a minimum dwell of 1.
  - Wait counter reaches MAX_WAIT with mem_busy still 1 -> HALTED, halt_err=1.
- HALTED:
  - halted=1, fetch_stall=1.
  - resume=1 -> RUN: halted<=0, halt_err<=0, fetch_stall<=0.
  - halt_pc_q is retained until the next capture.
- Ignored inputs:
  - syscall_halt outside RUN, including a re-assertion during KILL/DRAIN/MEMWAIT; halt_pc_q is not overwritten.
  - resume outside HALTED.
- resume and syscall_halt both high in HALTED: resume wins and the FSM goes to RUN. syscall_halt is re-sampled the following cycle.
- Reset mid-sequence: immediate return to RUN with all outputs cleared; no partial kill pulse survives.
- mem_busy is a don't-care in RUN, KILL and DRAIN.

Optional Feature:
Macro: HALT_CTRL_STATS_EN.

When defined:
- Adds input instr_retire (1) and outputs cycle_cnt (CNT_W) and instret_cnt (CNT_W).
- cycle_cnt increments every cycle in RUN, KILL, DRAIN and MEMWAIT.
- instret_cnt increments when instr_retire=1 in those same states.
- Both counters freeze in HALTED, saturate at all-ones, and clear on reset and on the resume transition.
- On HALTED entry, simulation-only code prints both counts and halt_pc_q.

When undefined: those ports and registers do not exist, and behaviour is otherwise identical.

Test Plan:
1. Reset, then syscall_halt=1 with halt_pc=0x0040_0020, mem_busy=0, DRAIN_CYCLES=4 -> kill_younger pulses in cycle N+1 only; halted=1 in cycle N+7 (1 KILL + 4 DRAIN + 1 MEMWAIT); halt_pc_q=0x0040_0020; halt_err=0.
2. mem_busy held 1 for 10 cycles after DRAIN -> halted rises the cycle after mem_busy falls; halt_err=0.
3. mem_busy stuck 1, MAX_WAIT=8 -> halted=1 with halt_err=1 after 8 MEMWAIT cycles; fetch_stall stays 1 throughout.
4. In HALTED, pulse resume with syscall_halt also high -> RUN next cycle with halted=0 and fetch_stall=0; syscall_halt still high then re-triggers KILL one cycle later.
5. Assert rst_b=0 asynchronously mid-DRAIN -> all outputs 0 immediately, without waiting for a clock edge; a new syscall_halt afterwards runs the full sequence again.
6. With HALT_CTRL_STATS_EN, 100 RUN cycles including 60 retire pulses, then exit -> cycle_cnt=100+1+DRAIN_CYCLES+1 and instret_cnt=60, both frozen in HALTED and cleared on resume.
